// File: rtl/spi_pkg.sv
// Shared definitions for the PmodACL (ADXL345) SPI link: FSM state codes,
// frame geometry and the accelerometer command words used by the controller.
package spi_pkg;

    localparam int FRAME_BITS = 16;
    localparam int RX_BITS    = 8;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_LEAD     = 3'd1;
    localparam state_t ST_SHIFT    = 3'd2;
    localparam state_t ST_TRAIL    = 3'd3;
    localparam state_t ST_GAP      = 3'd4;
    localparam state_t ST_WAIT_LOW = 3'd5;

    // {R/W, MB, address[5:0], data[7:0]} frames for the ADXL345
    localparam logic [15:0] CMD_POWER_CTL   = 16'h2D08;
    localparam logic [15:0] CMD_BW_RATE     = 16'h2C08;
    localparam logic [15:0] CMD_DATA_FORMAT = 16'h3100;
    localparam logic [15:0] CMD_READ_Y0     = 16'hB400;
    localparam logic [15:0] CMD_READ_Y1     = 16'hB500;

    // Slave select is asserted only while the frame itself is on the wire.
    function automatic logic frame_active(input state_t s);
        return (s == ST_LEAD) || (s == ST_SHIFT) || (s == ST_TRAIL);
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// Half-period timer and SCLK generator: tick every CLK_DIV enabled cycles,
// SCLK toggles on ticks while toggle_en is high and idles high otherwise.
module spi_sclk_gen #(
    parameter int CLK_DIV = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic toggle_en,
    output logic sclk,
    output logic tick,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_reg;
    logic          sclk_reg;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt_reg <= '0;
        end else if (cnt_reg == LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            sclk_reg <= 1'b1;
        end else if (toggle_en && tick) begin
            sclk_reg <= ~sclk_reg;
        end
    end

    // Strobes flag the edge on which sclk will change, so the caller updates
    // its shift registers on the same clock edge the pin moves.
    assign tick = en && (cnt_reg == LAST);
    assign rise = tick && toggle_en && !sclk_reg;
    assign fall = tick && toggle_en && sclk_reg;
    assign sclk = sclk_reg;

endmodule

// File: rtl/spi_interface.sv
// SPI mode 3 shift engine for the PmodACL: sends a 16-bit frame MSB first and
// returns the low byte of the word shifted in on MISO with a one-cycle done.
module spi_interface
    import spi_pkg::*;
#(
    parameter int CLK_DIV    = 50,
    parameter int FRAME_BITS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        transmit,
    input  logic [15:0] txdata,
    input  logic        sdi,
    output logic        sdo,
    output logic        sclk,
    output logic        ss,
    output logic        busy,
    output logic        done,
    output logic [7:0]  rxdata
);

    state_t state_reg;
    state_t state_next;

    logic [FRAME_BITS-1:0] tx_sr_reg;
    logic [FRAME_BITS-1:0] rx_sr_reg;
    logic [4:0]            bit_cnt_reg;
    logic [RX_BITS-1:0]    rxdata_reg;
    logic                  done_reg;
    logic                  ss_reg;
    logic                  busy_reg;

    logic gen_en;
    logic gen_toggle;
    logic tick;
    logic rise;
    logic fall;

    assign gen_en     = (state_reg == ST_LEAD) || (state_reg == ST_SHIFT) ||
                        (state_reg == ST_TRAIL) || (state_reg == ST_GAP);
    assign gen_toggle = (state_reg == ST_LEAD) || (state_reg == ST_SHIFT);

    spi_sclk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sclk_gen (
        .clk      (clk),
        .rst      (rst),
        .en       (gen_en),
        .toggle_en(gen_toggle),
        .sclk     (sclk),
        .tick     (tick),
        .rise     (rise),
        .fall     (fall)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:     if (transmit) state_next = ST_LEAD;
            ST_LEAD:     if (tick) state_next = ST_SHIFT;
            ST_SHIFT:    if (rise && bit_cnt_reg == 5'(FRAME_BITS - 1)) state_next = ST_TRAIL;
            ST_TRAIL:    if (tick) state_next = ST_GAP;
            ST_GAP:      if (tick) state_next = ST_WAIT_LOW;
            // Hold here until the controller drops transmit to avoid a retrigger.
            ST_WAIT_LOW: if (!transmit) state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            tx_sr_reg   <= '0;
            rx_sr_reg   <= '0;
            bit_cnt_reg <= '0;
            rxdata_reg  <= '0;
            done_reg    <= 1'b0;
            ss_reg      <= 1'b1;
            busy_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= 1'b0;
            ss_reg    <= !frame_active(state_next);
            busy_reg  <= (state_next != ST_IDLE) && (state_next != ST_WAIT_LOW);

            if (state_reg == ST_IDLE && transmit) begin
                tx_sr_reg   <= txdata;
                rx_sr_reg   <= '0;
                bit_cnt_reg <= '0;
            end

            // The first falling edge happens in LEAD, so every fall seen in
            // SHIFT advances MOSI to the next bit.
            if (state_reg == ST_SHIFT) begin
                if (rise) begin
                    rx_sr_reg   <= {rx_sr_reg[FRAME_BITS-2:0], sdi};
                    bit_cnt_reg <= bit_cnt_reg + 5'd1;
                end
                if (fall) begin
                    tx_sr_reg <= {tx_sr_reg[FRAME_BITS-2:0], 1'b0};
                end
            end

            if (state_reg == ST_TRAIL && tick) begin
                done_reg   <= 1'b1;
                rxdata_reg <= rx_sr_reg[RX_BITS-1:0];
            end
        end
    end

    assign sdo    = ss_reg ? 1'b0 : tx_sr_reg[FRAME_BITS-1];
    assign ss     = ss_reg;
    assign busy   = busy_reg;
    assign done   = done_reg;
    assign rxdata = rxdata_reg;

endmodule

// File: tb/tb_spi_interface.sv
// Scoreboard bench for spi_interface: frames are queued with their expected
// MOSI word and returned byte; a monitor checks each frame when done fires.
module tb_spi_interface;
    import spi_pkg::*;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        transmit;
    logic [15:0] txdata;
    logic        sdi = 1'b0;
    logic        sdo;
    logic        sclk;
    logic        ss;
    logic        busy;
    logic        done;
    logic [7:0]  rxdata;

    always #5 clk = ~clk;

    spi_interface #(
        .CLK_DIV   (T),
        .FRAME_BITS(16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .transmit(transmit),
        .txdata  (txdata),
        .sdi     (sdi),
        .sdo     (sdo),
        .sclk    (sclk),
        .ss      (ss),
        .busy    (busy),
        .done    (done),
        .rxdata  (rxdata)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] tx;
        logic [7:0]  rx;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] slave_q[$];
    logic [7:0]  model_rx = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Slave model: mode 3, presents bit 15 at select, then the next bit after
    // each falling sclk edge beyond the first.
    logic [15:0] slave_word = 16'h0;
    int          slave_falls = 0;
    logic        slave_active = 1'b0;
    logic        slave_sclk_prev = 1'b1;

    always @(negedge clk) begin
        if (ss !== 1'b0) begin
            slave_active = 1'b0;
            slave_falls  = 0;
            sdi          = 1'b0;
        end else if (!slave_active) begin
            slave_active = 1'b1;
            slave_word   = (slave_q.size() > 0) ? slave_q.pop_front() : 16'h0;
            sdi          = slave_word[15];
        end else if (slave_sclk_prev && !sclk) begin
            slave_falls++;
            if (slave_falls > 1 && slave_falls <= 16) sdi = slave_word[16 - slave_falls];
        end
        slave_sclk_prev = sclk;
    end

    // Monitor: collects MOSI at sclk rises and the select width, checks on done.
    logic [15:0] mon_mosi = 16'h0;
    int          mon_rises = 0;
    int          mon_ss_low = 0;
    logic        mon_sclk_prev = 1'b1;
    logic        mon_done_prev = 1'b0;
    exp_t        mon_e;

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            mon_mosi      = 16'h0;
            mon_rises     = 0;
            mon_ss_low    = 0;
            mon_sclk_prev = 1'b1;
            mon_done_prev = 1'b0;
        end else begin
            if (ss === 1'b0) mon_ss_low++;
            if (!mon_sclk_prev && sclk === 1'b1 && ss === 1'b0) begin
                mon_mosi = {mon_mosi[14:0], sdo};
                mon_rises++;
            end
            if (done === 1'b1) begin
                check("done_width", 32'(mon_done_prev), 32'(0));
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=done required=no_done rxdata=%0h", rxdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rxdata", 32'(rxdata), 32'(mon_e.rx));
                    check("mosi_word", 32'(mon_mosi), 32'(mon_e.tx));
                    check("sclk_rises", 32'(mon_rises), 32'(16));
                    check("ss_low_cycles", 32'(mon_ss_low), 32'(33 * T));
                    $display("frame tx=%h mosi=%h rx=%h exp_rx=%h rises=%0d ss_low=%0d",
                             mon_e.tx, mon_mosi, rxdata, mon_e.rx, mon_rises, mon_ss_low);
                end
                mon_mosi   = 16'h0;
                mon_rises  = 0;
                mon_ss_low = 0;
            end
            mon_sclk_prev = sclk;
            mon_done_prev = done;
        end
    end

    task automatic wait_not_busy();
        int n = 0;
        while (busy !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check("busy_timeout", 32'(busy), 32'(0));
    endtask

    task automatic run_frame(input logic [15:0] txd, input logic [15:0] resp,
                             input int hold, input bit change_tx);
        @(negedge clk);
        txdata   = txd;
        transmit = 1'b1;
        exp_q.push_back('{tx: txd, rx: resp[7:0]});
        slave_q.push_back(resp);
        repeat (hold) @(negedge clk);
        transmit = 1'b0;
        if (change_tx) begin
            repeat (20) @(negedge clk);
            txdata = 16'hFFFF;
        end
        wait_not_busy();
        model_rx = resp[7:0];
        repeat (3) @(negedge clk);
        check("rx_hold", 32'(rxdata), 32'(model_rx));
    endtask

    task automatic reset_mid_frame();
        int   rises = 0;
        int   n = 0;
        logic prev = 1'b1;
        @(negedge clk);
        txdata   = 16'($urandom);
        transmit = 1'b1;
        slave_q.push_back(16'($urandom));
        @(negedge clk);
        transmit = 1'b0;
        while (rises < 7 && n < 1000) begin
            @(negedge clk);
            if (!prev && sclk === 1'b1) rises++;
            prev = sclk;
            n++;
        end
        if (n >= 1000) check("rise7_timeout", 32'(rises), 32'(7));
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_ss", 32'(ss), 32'(1));
        check("rst_mid_sclk", 32'(sclk), 32'(1));
        check("rst_mid_done", 32'(done), 32'(0));
        check("rst_mid_rxdata", 32'(rxdata), 32'(0));
        check("rst_mid_busy", 32'(busy), 32'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_rx = 8'h00;
        repeat (3 * T) @(negedge clk);
        check("rst_mid_rx_hold", 32'(rxdata), 32'(model_rx));
    endtask

    task automatic held_transmit(input logic [15:0] txd, input logic [15:0] resp);
        @(negedge clk);
        txdata   = txd;
        transmit = 1'b1;
        exp_q.push_back('{tx: txd, rx: resp[7:0]});
        slave_q.push_back(resp);
        @(negedge clk);
        wait_not_busy();
        repeat (20) @(negedge clk);
        check("held_no_retrigger_busy", 32'(busy), 32'(0));
        check("held_no_retrigger_ss", 32'(ss), 32'(1));
        check("held_one_done", 32'(exp_q.size()), 32'(0));
        transmit = 1'b0;
        model_rx = resp[7:0];
        repeat (3) @(negedge clk);
        check("held_rx_hold", 32'(rxdata), 32'(model_rx));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        transmit = 1'b0;
        txdata   = 16'h0;
        repeat (2) @(negedge clk);
        check("reset_ss", 32'(ss), 32'(1));
        check("reset_sclk", 32'(sclk), 32'(1));
        check("reset_sdo", 32'(sdo), 32'(0));
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_done", 32'(done), 32'(0));
        check("reset_rxdata", 32'(rxdata), 32'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_frame(CMD_POWER_CTL, 16'($urandom), 2, 1'b0);
        run_frame(CMD_READ_Y0, 16'h005A, 2, 1'b0);
        reset_mid_frame();
        held_transmit(CMD_BW_RATE, 16'($urandom));
        run_frame(CMD_READ_Y1, 16'($urandom), 1, 1'b0);
        run_frame(CMD_DATA_FORMAT, 16'($urandom), 2, 1'b1);
        for (int i = 0; i < 10; i++) begin
            run_frame(16'($urandom), 16'($urandom), int'($urandom_range(1, 3)),
                      1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
